// File: rtl/pll_loop_filter_if.sv
// Signal bundle between the phase-frequency detector (master) and the PI loop filter (slave).
// The master drives the error stream and freeze control. The slave returns the oscillator
// control word and the lock flag.
interface pll_loop_filter_if #(
    parameter int unsigned ERR_W = 4,
    parameter int unsigned OUT_W = 16
);
    logic signed [ERR_W-1:0] error_in;
    logic                    sample_en;
    logic                    freeze;
    logic        [OUT_W-1:0] ctrl_word;
    logic                    ctrl_valid;
    logic                    locked;

    modport master (
        output error_in, sample_en, freeze,
        input  ctrl_word, ctrl_valid, locked
    );

    modport slave (
        input  error_in, sample_en, freeze,
        output ctrl_word, ctrl_valid, locked
    );
endinterface

// File: rtl/pll_loop_filter.sv
// Proportional-integral loop filter for the Tiny-PLL.
// The filter takes the signed +1/0/-1 phase-error stream and produces a saturated, unsigned
// oscillator control word.
// Stage 1 registers the proportional term and the integrator.
// Stage 2 forms CENTER + (acc >>> ACC_FRAC) + prop and clamps it to the output range.
// Optional lock detector: define PLL_LF_LOCK_DET_EN to build it. Otherwise `locked` is tied to 0.
module pll_loop_filter #(
    parameter int unsigned ERR_W     = 4,
    parameter int unsigned ACC_W     = 24,
    parameter int unsigned OUT_W     = 16,
    parameter int unsigned KP_SHIFT  = 6,
    parameter int unsigned KI_SHIFT  = 0,
    parameter int unsigned ACC_FRAC  = 8,
    parameter int unsigned CENTER    = 32'h8000,
    parameter int unsigned WIN_LEN   = 1024,
    parameter int unsigned LOCK_THR  = 16,
    parameter int unsigned LOCK_WINS = 4
) (
    input  logic               sys_clk,
    input  logic               rst,
    pll_loop_filter_if.slave   lf
);

    // The datapath must be wide enough that neither acc+err nor the three-term output sum can
    // wrap, including when OUT_W exceeds ACC_W.
    localparam int unsigned SH_MAX = (KP_SHIFT > KI_SHIFT) ? KP_SHIFT : KI_SHIFT;
    localparam int unsigned GAIN_W = ERR_W + SH_MAX;
    localparam int unsigned M1     = (ACC_W > OUT_W) ? ACC_W : OUT_W;
    localparam int unsigned M2     = (M1 > GAIN_W) ? M1 : GAIN_W;
    localparam int unsigned W      = M2 + 3;

    typedef logic signed [W-1:0] wide_t;

    localparam wide_t ACC_MAX = (wide_t'(1) <<< (ACC_W - 1)) - wide_t'(1);
    localparam wide_t ACC_MIN = -(wide_t'(1) <<< (ACC_W - 1));
    localparam wide_t OUT_MAX = (wide_t'(1) <<< OUT_W) - wide_t'(1);
    localparam wide_t CTR_W   = wide_t'(CENTER);

    logic signed [ACC_W-1:0] acc_q, acc_d, acc_sat;
    wide_t                   prop_q, prop_d;
    logic                    v1_q, v1_d;
    logic        [OUT_W-1:0] ctrl_q, ctrl_d;
    logic                    valid_q, valid_d;
    wide_t                   err_w, acc_sum, out_sum;

    // Stage 1 arithmetic: sign-extend the error, accumulate and saturate.
    always_comb begin
        err_w   = wide_t'(lf.error_in);
        acc_sum = wide_t'(acc_q) + (err_w <<< KI_SHIFT);
        if (acc_sum > ACC_MAX) begin
            acc_sat = ACC_W'(ACC_MAX);
        end else if (acc_sum < ACC_MIN) begin
            acc_sat = ACC_W'(ACC_MIN);
        end else begin
            acc_sat = ACC_W'(acc_sum);
        end
    end

    // Stage 1 next state. Freeze only gates the integrator; prop and v1 stay live.
    always_comb begin
        prop_d = prop_q;
        acc_d  = acc_q;
        v1_d   = 1'b0;
        if (lf.sample_en) begin
            prop_d = err_w <<< KP_SHIFT;
            v1_d   = 1'b1;
            if (!lf.freeze) begin
                acc_d = acc_sat;
            end
        end
    end

    // Stage 2 next state: sum around the free-running centre and clamp to the unsigned range.
    always_comb begin
        out_sum = CTR_W + (wide_t'(acc_q) >>> ACC_FRAC) + prop_q;
        ctrl_d  = ctrl_q;
        valid_d = 1'b0;
        if (v1_q) begin
            valid_d = 1'b1;
            if (out_sum < wide_t'(0)) begin
                ctrl_d = '0;
            end else if (out_sum > OUT_MAX) begin
                ctrl_d = '1;
            end else begin
                ctrl_d = OUT_W'(out_sum);
            end
        end
    end

    // Pipeline registers with asynchronous reset to the free-running state.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            prop_q  <= '0;
            v1_q    <= 1'b0;
            ctrl_q  <= OUT_W'(CENTER);
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            prop_q  <= prop_d;
            v1_q    <= v1_d;
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
        end
    end

    assign lf.ctrl_word  = ctrl_q;
    assign lf.ctrl_valid = valid_q;

`ifdef PLL_LF_LOCK_DET_EN
    localparam int unsigned WIN_W  = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int unsigned ACT_W  = $clog2(WIN_LEN + 1);
    localparam int unsigned GOOD_W = $clog2(LOCK_WINS + 1);

    logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
    logic [ACT_W-1:0]  act_cnt_q, act_cnt_d, act_now;
    logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
    logic              locked_q, locked_d;
    logic              active;

    // Window bookkeeping. act_now includes the current cycle so the last cycle of a window counts.
    always_comb begin
        active     = lf.sample_en && (lf.error_in != '0);
        act_now    = act_cnt_q;
        if (active && (act_cnt_q != ACT_W'(WIN_LEN))) begin
            act_now = act_cnt_q + 1'b1;
        end
        win_cnt_d  = win_cnt_q + 1'b1;
        act_cnt_d  = act_now;
        good_cnt_d = good_cnt_q;
        locked_d   = (good_cnt_q == GOOD_W'(LOCK_WINS));
        if (win_cnt_q == WIN_W'(WIN_LEN - 1)) begin
            win_cnt_d = '0;
            act_cnt_d = '0;
            if (32'(act_now) <= LOCK_THR) begin
                if (good_cnt_q != GOOD_W'(LOCK_WINS)) begin
                    good_cnt_d = good_cnt_q + 1'b1;
                end
            end else begin
                good_cnt_d = '0;
                locked_d   = 1'b0;
            end
        end
    end

    // Lock detector state.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            win_cnt_q  <= '0;
            act_cnt_q  <= '0;
            good_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            win_cnt_q  <= win_cnt_d;
            act_cnt_q  <= act_cnt_d;
            good_cnt_q <= good_cnt_d;
            locked_q   <= locked_d;
        end
    end

    assign lf.locked = locked_q;
`else
    assign lf.locked = 1'b0;
`endif

endmodule
